bel_fft_avl_mem_slave: RTL and testbench



---
 rtl/bel_fft_avl_mem_slave_pkg.sv | 23 ++
 rtl/bel_fft_sp_ram_sync.sv | 22 ++
 rtl/bel_fft_avl_mem_slave.sv | 120 ++++++++++++
 tb/tb_bel_fft_avl_mem_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bel_fft_avl_mem_slave_pkg.sv
// Shared widths and {re, im} packing helpers for the FFT sample memory slave.
package bel_fft_avl_mem_slave_pkg;

    localparam int BEL_FFT_MIF_AWIDTH = 10;
    localparam int BEL_FFT_DWIDTH     = 32;
    localparam int WORD_WIDTH         = 16;

    typedef logic [WORD_WIDTH-1:0]     half_t;
    typedef logic [BEL_FFT_DWIDTH-1:0] cword_t;

    function automatic cword_t cplx_pack(half_t re, half_t im);
        return {re, im};
    endfunction

    function automatic half_t cplx_re(cword_t w);
        return w[BEL_FFT_DWIDTH-1 -: WORD_WIDTH];
    endfunction

    function automatic half_t cplx_im(cword_t w);
        return w[WORD_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/bel_fft_sp_ram_sync.sv
// Single-port sample RAM with registered synchronous read (read-before-write), no reset.
module bel_fft_sp_ram_sync #(
    parameter int aw = 10,
    parameter int dw = 32
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [aw-1:0] adr,
    input  logic [dw-1:0] wdat,
    output logic [dw-1:0] rdat
);

    logic [dw-1:0] mem [2**aw];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[adr] <= wdat;
        end
        rdat <= mem[adr];
    end

endmodule

// File: rtl/bel_fft_avl_mem_slave.sv
// Avalon-MM pipelined slave over the FFT sample RAM, shared with the audio loader port.
module bel_fft_avl_mem_slave
    import bel_fft_avl_mem_slave_pkg::*;
#(
    parameter int aw           = BEL_FFT_MIF_AWIDTH,
    parameter int dw           = BEL_FFT_DWIDTH,
    parameter int word_width   = WORD_WIDTH,
    parameter int rd_latency   = 2,
    parameter int starve_limit = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [aw-1:0] address,
    input  logic [dw-1:0] writedata,
    input  logic          read,
    input  logic          write,
    output logic          waitrequest,
    output logic [dw-1:0] readdata,
    output logic          readdatavalid,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    input  logic [aw-1:0] load_adr_i,
    input  logic [dw-1:0] load_dat_i
);

    localparam logic [7:0] starve_max = 8'(starve_limit);

    logic                  av_req;
    logic                  starved;
    logic                  grant_load;
    logic                  av_acc;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [7:0]            starve_cnt;
    logic                  ram_we;
    logic [aw-1:0]         ram_adr;
    logic [dw-1:0]         src_dat;
    logic [dw-1:0]         ram_wdat;
    logic [dw-1:0]         ram_rdat;
    logic [dw-1:0]         pipe_dat;
    logic [dw-1:0]         hold_dat;
    logic [rd_latency-1:0] vld;

    // Loader normally wins; once it has starved a waiting Avalon request long enough, it yields.
    assign av_req       = read | write;
    assign starved      = av_req && (starve_cnt == starve_max);
    assign grant_load   = load_valid_i & ~starved & ~rst_i;
    assign load_ready_o = grant_load;
    assign waitrequest  = rst_i | (grant_load & av_req);

    assign av_acc = av_req & ~waitrequest;
    assign wr_acc = write & ~waitrequest;
    assign rd_acc = read & ~write & ~waitrequest;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (!av_req || av_acc) begin
            starve_cnt <= '0;
        end else if (grant_load && starve_cnt != starve_max) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Arbitration guarantees at most one of loader / Avalon write per cycle.
    assign ram_we   = wr_acc | grant_load;
    assign ram_adr  = grant_load ? load_adr_i : address;
    assign src_dat  = grant_load ? load_dat_i : writedata;
    assign ram_wdat = {src_dat[dw-1:word_width], src_dat[word_width-1:0]};

    bel_fft_sp_ram_sync #(
        .aw (aw),
        .dw (dw)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .adr   (ram_adr),
        .wdat  (ram_wdat),
        .rdat  (ram_rdat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= '0;
        end else begin
            vld[0] <= rd_acc;
            for (int i = 1; i < rd_latency; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // The RAM output register is the first latency stage; rd_latency-1 more follow.
    if (rd_latency == 1) begin : g_lat1
        assign pipe_dat = ram_rdat;
    end else begin : g_latn
        logic [dw-1:0] dly [rd_latency-1];

        always_ff @(posedge clk_i) begin
            dly[0] <= ram_rdat;
            for (int i = 1; i < rd_latency-1; i++) begin
                dly[i] <= dly[i-1];
            end
        end

        assign pipe_dat = dly[rd_latency-2];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_dat <= '0;
        end else if (vld[rd_latency-1]) begin
            hold_dat <= pipe_dat;
        end
    end

    assign readdatavalid = vld[rd_latency-1];
    assign readdata      = readdatavalid ? pipe_dat : hold_dat;

endmodule

// File: tb/tb_bel_fft_avl_mem_slave.sv
// Scoreboard bench for bel_fft_avl_mem_slave: memory/arbiter reference model plus directed scenarios.
module tb_bel_fft_avl_mem_slave;
    import bel_fft_avl_mem_slave_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int RDLAT = 2;
    localparam int LIMIT = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] writedata = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          load_valid_i = 1'b0;
    logic          load_ready_o;
    logic [AW-1:0] load_adr_i = '0;
    logic [DW-1:0] load_dat_i = '0;

    bel_fft_avl_mem_slave #(
        .aw           (AW),
        .dw           (DW),
        .word_width   (16),
        .rd_latency   (RDLAT),
        .starve_limit (LIMIT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .address       (address),
        .writedata     (writedata),
        .read          (read),
        .write         (write),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .load_valid_i  (load_valid_i),
        .load_ready_o  (load_ready_o),
        .load_adr_i    (load_adr_i),
        .load_dat_i    (load_dat_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } rsp_t;

    int            n_err = 0;
    int            n_chk = 0;
    int            cyc = 0;
    rsp_t          sb[$];
    logic [DW-1:0] mem_m [1024];
    int            scnt = 0;
    logic [DW-1:0] last_rd = '0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration, starvation counter, memory contents, response queue.
    always @(negedge clk_i) begin : mon
        logic av;
        logic e_ready;
        logic e_wait;
        rsp_t r;
        av = read | write;
        if (rst_i) begin
            chk("rst_wait", waitrequest, 1);
            chk("rst_ready", load_ready_o, 0);
            sb.delete();
            scnt = 0;
            last_rd = '0;
        end else begin
            e_ready = load_valid_i && !(av && scnt == LIMIT);
            e_wait  = e_ready && av;
            chk("load_ready", load_ready_o, e_ready);
            chk("waitrequest", waitrequest, e_wait);
            if (readdatavalid) begin
                if (sb.size() == 0) begin
                    chk("rdv_unexpected", readdatavalid, 0);
                end else begin
                    r = sb.pop_front();
                    chk("rd_data", readdata, r.dat);
                    chk("rd_latency", cyc, r.due);
                end
                last_rd = readdata;
            end else begin
                chk("rd_hold", readdata, last_rd);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("rdv_missing", readdatavalid, 1);
                    void'(sb.pop_front());
                end
            end
            if (e_ready) begin
                mem_m[load_adr_i] = load_dat_i;
            end else if (av) begin
                if (write) mem_m[address] = writedata;
                else sb.push_back('{dat: mem_m[address], due: cyc + RDLAT});
            end
            if (!av || !e_wait) scnt = 0;
            else if (scnt < LIMIT) scnt++;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        read = 1'b0;
        write = 1'b0;
        load_valid_i = 1'b0;
    endtask

    task automatic av_op(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        read = rd;
        write = wr;
        address = a;
        writedata = d;
        while (!acc && n < 100) begin
            @(negedge clk_i);
            acc = !waitrequest;
            n++;
            step();
        end
        if (!acc) chk("accept_timeout", waitrequest, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g;
        int   n;
        logic acc;

        repeat (3) step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_rdv", readdatavalid, 0);
        chk("reset_rdata", readdata, 0);
        step();

        // 1: write then read next cycle
        av_op(1'b0, 1'b1, 10'd5, 32'h1234ABCD);
        av_op(1'b1, 1'b0, 10'd5, '0);
        idle();
        drain();
        repeat (3) step();
        chk("t1_data", last_rd, 32'h1234ABCD);

        // 2: back-to-back reads
        for (int i = 0; i < 8; i++) av_op(1'b0, 1'b1, AW'(i), cplx_pack(16'(i), 16'(i)));
        for (int i = 0; i < 8; i++) av_op(1'b1, 1'b0, AW'(i), '0);
        idle();
        drain();
        chk("t2_last", last_rd, 32'h00070007);

        // 3: starvation guard
        load_valid_i = 1'b1;
        load_adr_i = 10'd200;
        load_dat_i = 32'hCAFE0000;
        read = 1'b1;
        address = 10'd3;
        g = 0;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk_i);
            acc = !waitrequest;
            if (acc) chk("t3_block", load_ready_o, 0);
            else if (load_ready_o) g++;
            n++;
            step();
        end
        chk("t3_accepted", acc, 1);
        chk("t3_grants", g, LIMIT);
        read = 1'b0;
        @(negedge clk_i);
        chk("t3_resume", load_ready_o, 1);
        step();
        load_valid_i = 1'b0;
        drain();
        chk("t3_data", last_rd, 32'h00030003);

        // 4: loader write visible to next-cycle read
        load_valid_i = 1'b1;
        load_adr_i = 10'd9;
        load_dat_i = 32'hFFFF0001;
        @(negedge clk_i);
        chk("t4_ready", load_ready_o, 1);
        step();
        load_valid_i = 1'b0;
        av_op(1'b1, 1'b0, 10'd9, '0);
        idle();
        drain();
        chk("t4_data", last_rd, 32'hFFFF0001);

        // 5: reset while reads in flight
        av_op(1'b1, 1'b0, 10'd5, '0);
        av_op(1'b1, 1'b0, 10'd9, '0);
        idle();
        load_valid_i = 1'b1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t5_wait", waitrequest, 1);
        chk("t5_ready", load_ready_o, 0);
        step();
        rst_i = 1'b0;
        load_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t5_no_rdv", readdatavalid, 0);
            chk("t5_rdata", readdata, 0);
            step();
        end

        // 6: illegal read+write performs write only
        av_op(1'b1, 1'b1, 10'd12, 32'h00AA0055);
        idle();
        repeat (4) step();
        av_op(1'b1, 1'b0, 10'd12, '0);
        idle();
        drain();
        chk("t6_data", last_rd, 32'h00AA0055);

        // mixed traffic with loader contention
        for (int i = 0; i < 16; i++) av_op(1'b0, 1'b1, AW'(i), 32'($urandom));
        idle();
        for (int k = 0; k < 60; k++) begin
            int op;
            op = int'($urandom_range(0, 3));
            read = (op == 1);
            write = (op == 2);
            address = AW'($urandom_range(0, 15));
            writedata = 32'($urandom);
            load_valid_i = 1'($urandom_range(0, 1));
            load_adr_i = AW'($urandom_range(0, 15));
            load_dat_i = 32'($urandom);
            step();
        end
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
